// File: rtl/execute_result_queue_pkg.sv
// Shared types for the execute result queue.
//   execute_entry_t : one completed execute-stage result, packed MSB-first
//                     {pc, op, csr_addr, dst_reg_addr, dst_int_reg_value,
//                      dst_fp_reg_value, branch_taken, branch_target,
//                      trap_info, trap_return, debug_insn}
//   ENTRY_W         : packed width of execute_entry_t
//   is_serializing  : entry must drain alone (trap or trap return)
// Field widths are fixed here because the packed struct defines the port width.
package execute_result_queue_pkg;

    localparam int XLEN   = 32;
    localparam int FLEN   = 64;
    localparam int OP_W   = 64;
    localparam int TRAP_W = 67;   // bit TRAP_W-1 is the trap valid flag

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [OP_W-1:0]   op;
        logic [11:0]       csr_addr;
        logic [4:0]        dst_reg_addr;
        logic [XLEN-1:0]   dst_int_reg_value;
        logic [FLEN-1:0]   dst_fp_reg_value;
        logic              branch_taken;
        logic [XLEN-1:0]   branch_target;
        logic [TRAP_W-1:0] trap_info;
        logic              trap_return;
        logic [31:0]       debug_insn;
    } execute_entry_t;

    localparam int ENTRY_W = $bits(execute_entry_t);

    // A trapping or trap-returning entry blocks further enqueues until it leaves.
    function automatic logic is_serializing(input execute_entry_t e);
        return e.trap_info[TRAP_W-1] | e.trap_return;
    endfunction

endpackage

// File: rtl/execute_queue_storage.sv
// Entry storage for the execute result queue.
//   clk   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : entry to write
//   raddr : read slot
//   rdata : entry at raddr (combinational read)
// Storage is intentionally not reset; validity is tracked by the pointers.
module execute_queue_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/execute_result_queue_checker.sv
// Upstream protocol checker for the execute result queue input.
//   clk, rstN : clock, synchronous active-low reset
//   inValid, inReady, inEntry : observed enqueue handshake
// A stalled entry must not change until it is accepted or withdrawn.
module execute_result_queue_checker
    import execute_result_queue_pkg::*;
(
    input logic               clk,
    input logic               rstN,
    input logic               inValid,
    input logic               inReady,
    input logic [ENTRY_W-1:0] inEntry
);

    a_in_entry_stable: assert property (
        @(posedge clk) disable iff (!rstN)
        (inValid && !inReady) |=> (!inValid || $stable(inEntry))
    );

endmodule

// File: rtl/execute_result_queue.sv
// Elastic FIFO between execute and memory/commit stages.
//   clk, rstN   : clock, synchronous active-low reset
//   flush       : drop all resident entries and the current input
//   inValid/inReady/inEntry    : enqueue handshake from execute
//   outValid/outReady/outEntry : dequeue handshake to the next stage
//   count       : occupancy
//   trapPending : a serializing entry is resident
module execute_result_queue
    import execute_result_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     flush,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [ENTRY_W-1:0]       inEntry,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [ENTRY_W-1:0]       outEntry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     trapPending
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;   // extra wrap bit distinguishes full from empty

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] trap_ptr_q, trap_ptr_d;
    logic             trap_pending_q, trap_pending_d;

    logic full_s;
    logic empty_s;
    logic in_ready_s;
    logic enq_s;
    logic deq_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready depends only on registered state plus rstN/flush, never on outReady.
    assign in_ready_s = rstN && !full_s && !trap_pending_q && !flush;
    assign enq_s      = inValid && in_ready_s;
    assign deq_s      = !empty_s && outReady && !flush;

    // Next-state for pointers, occupancy and trap tracking.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        trap_ptr_d     = trap_ptr_q;
        trap_pending_d = trap_pending_q;
        if (flush) begin
            rd_ptr_d       = wr_ptr_q;
            count_d        = {PTR_W{1'b0}};
            trap_pending_d = 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + PTR_W'(1);
                2'b01:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
            // Enqueue is blocked while pending, so set and clear never coincide.
            if (deq_s && trap_pending_q && (rd_ptr_q == trap_ptr_q)) begin
                trap_pending_d = 1'b0;
            end else if (enq_s && is_serializing(execute_entry_t'(inEntry))) begin
                trap_pending_d = 1'b1;
                trap_ptr_d     = wr_ptr_q;
            end else begin
                trap_pending_d = trap_pending_q;
            end
        end
    end

    // Control state registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            count_q        <= {PTR_W{1'b0}};
            trap_ptr_q     <= {PTR_W{1'b0}};
            trap_pending_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            trap_ptr_q     <= trap_ptr_d;
            trap_pending_q <= trap_pending_d;
        end
    end

    execute_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk   (clk),
        .we    (enq_s),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (inEntry),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (outEntry)
    );

    assign inReady     = in_ready_s;
    assign outValid    = !empty_s;
    assign count       = count_q;
    assign trapPending = trap_pending_q;

endmodule

// File: doc/execute_result_queue.md
Name: execute_result_queue

Overview:
- Parametrised, elastic successor to the single-slot execute→memory stage register.
- Buffers up to DEPTH completed execute results (pc, op, csr/dst addresses, int/fp results, branch, trap) in FIFO order, with valid/ready handshakes on both sides.
- Adds pipeline flush, trap serialisation and an occupancy count.
- Sits between the execute stage and the memory/commit stage.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- XLEN, 32, width of pc, branchTarget and dstIntRegValue.
- FLEN, 64, width of dstFpRegValue.
- OP_W, 64, width of opaque packed Op.
- TRAP_W, 67, width of packed TrapInfo; bit TRAP_W-1 is the trap valid flag.

Ports:
- clk  in  1  clock
- rstN  in  1  synchronous active-low reset
- flush  in  1  discard all entries and the current input
- inValid  in  1  execute stage presents an entry
- inReady  out  1  queue accepts the entry this cycle
- inEntry  in  ENTRY_W  packed ExecuteEntry {pc, op, csrAddr[12], dstRegAddr[5], dstIntRegValue, dstFpRegValue, branchTaken, branchTarget, trapInfo, trapReturn, debugInsn[32]}
- outValid  out  1  head entry valid
- outReady  in  1  next stage consumes head
- outEntry  out  ENTRY_W  head entry; don't-care when outValid=0
- count  out  $clog2(DEPTH)+1  current occupancy
- trapPending  out  1  a trap- or trapReturn-carrying entry is resident

Behaviour:
- Reset (rstN=0 at posedge): rdPtr=wrPtr=0; count=0; outValid=0; trapPending=0; inReady=0 during the reset cycle. Storage is not cleared.
- Pointers are $clog2(DEPTH)+1 bits, so wrap is natural modulo 2·DEPTH.
  - Full = MSBs differ and low bits equal.
  - Empty = pointers equal.
- Enqueue fires when inValid && inReady. Write at wrPtr, then wrPtr+1.
- Dequeue fires when outValid && outReady. rdPtr+1.
- outEntry = storage[rdPtr] (registered storage, combinational read).
- outValid = !empty.
- Latency: an entry enqueued at edge N is visible on outEntry/outValid after edge N (1 cycle). There is no same-cycle bypass.
- inReady = rstN && !full && !trapPending && !flush.
  - Full: simultaneous dequeue does not raise inReady in the same cycle (no combinational ready path in→out).
- Trap serialisation:
  - An enqueue with trapInfo valid or trapReturn=1 sets trapPending next cycle.
  - trapPending clears on dequeue of that entry. The entry is tracked by a saved pointer (trapPtr).
  - While trapPending is set, no further enqueue occurs.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
  - Empty + enqueue + outReady: no dequeue this cycle (outValid=0).
- flush=1 at an edge:
  - rdPtr←wrPtr, count←0, trapPending←0.
  - The input is not accepted, and a dequeue in the same cycle is ignored.
  - flush has priority over all events.
  - Reset has priority over flush.
- count = wrPtr − rdPtr, registered and updated consistently with the pointers.
- Assertion (sim only): inEntry is stable while inValid && !inReady. This is an upstream obligation, flagged not enforced.

Decomposition:
- ExecuteQueueTypes package:
  - ExecuteEntry packed struct.
  - ENTRY_W localparam derived from XLEN/FLEN/OP_W/TRAP_W.
  - Helper function isSerializing(ExecuteEntry).
- One sub-module, execute_queue_storage:
  - DEPTH×ENTRY_W register array, one write port, one async read port, no reset.
- Pointer/handshake/trap control stays in the top.

Test Plan:
- Fill/drain: DEPTH=4, outReady=0, 5 back-to-back inValid with pc=0x100,0x104,…
  - Expect inReady low after 4 accepts and count=4.
  - Then outReady=1: outEntry.pc 0x100..0x10C in order, count back to 0, fifth entry accepted only after a slot frees.
- Wrap-around: 10 sequential enqueue/dequeue pairs with outReady=1 continuously.
  - Pointers wrap past 2·DEPTH.
  - Output pc sequence matches input exactly; count never exceeds 1.
- Trap serialisation: enqueue A (normal), B (trapInfo valid, cause 2), C (normal), with outReady=0.
  - B accepted, trapPending=1, C held with inReady=0.
  - C is accepted only in the cycle after B dequeues.
- Flush: 3 entries resident, flush=1 with simultaneous inValid and outReady.
  - Next cycle count=0, outValid=0, trapPending=0.
  - Input not accepted; nothing dequeued counts.
- Reset mid-operation: 2 entries resident plus trapPending, rstN=0 for one edge.
  - outValid=0, count=0, trapPending=0, inReady=0 during reset.
  - After release, normal enqueue works with pc=0x200 appearing 1 cycle later.
- Simultaneous enq/deq at full: count=4, inValid=1, outReady=1.
  - Head dequeued, input not accepted that cycle (inReady=0), count=3.
